// File: rtl/pixel_io_pkg.sv
// Shared definitions for the pixel array byte-stream paths (readout and loader).
// Holds the loader state encoding, TIFF magic bytes and default header/trailer lengths.
package pixel_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PIXELS,
    ST_WRITE,
    ST_TRAILER,
    ST_DONE
  } ldr_state_t;

  localparam logic [7:0] TIFF_MAGIC0 = 8'h4D;
  localparam logic [7:0] TIFF_MAGIC1 = 8'h4D;
  localparam logic [7:0] TIFF_MAGIC2 = 8'h00;
  localparam logic [7:0] TIFF_MAGIC3 = 8'h2A;

  localparam int unsigned TIFF_HDR_BYTES = 8;
  localparam int unsigned TIFF_TRL_BYTES = 126;

  function automatic logic [7:0] tiff_magic(input logic [1:0] idx);
    case (idx)
      2'd0:    return TIFF_MAGIC0;
      2'd1:    return TIFF_MAGIC1;
      2'd2:    return TIFF_MAGIC2;
      default: return TIFF_MAGIC3;
    endcase
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tiff_row_assembler.sv
// Row register for the TIFF loader: writes one byte lane per load, selected by lane.
// Contents persist between rows; each lane is overwritten before the next strobe.
module tiff_row_assembler #(
  parameter int unsigned COLUMNS = 256,
  parameter int unsigned BW      = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [BW-1:0]          lane,
  input  logic [7:0]             byte_in,
  output logic [8*COLUMNS-1:0]   row_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_data <= '0;
    end else if (load_en) begin
      for (int unsigned i = 0; i < COLUMNS; i++) begin
        if (lane == BW'(i)) row_data[8*i +: 8] <= byte_in;
      end
    end
  end

endmodule

// File: rtl/tiff_row_loader.sv
// Loads a big-endian TIFF byte stream into the pixel array one row at a time.
// Define TIFF_HDR_CHECK_EN to check the 4 magic header bytes and raise error on mismatch.
module tiff_row_loader
  import pixel_io_pkg::*;
#(
  parameter int unsigned ROWS      = 256,
  parameter int unsigned COLUMNS   = 256,
  parameter int unsigned HDR_BYTES = TIFF_HDR_BYTES,
  parameter int unsigned TRL_BYTES = TIFF_TRL_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [8*COLUMNS-1:0] row_data,
  output logic [ROWS-1:0]      write_array,
  output logic                 loading,
  output logic                 frame_done,
  output logic                 error
);

  localparam int unsigned BW = $clog2(max3(COLUMNS, HDR_BYTES, TRL_BYTES)) + 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  ldr_state_t    state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          accept;
  logic          pix_load;
`ifdef TIFF_HDR_CHECK_EN
  logic          hdr_bad;
  logic          err_set, err_clr;

  assign hdr_bad = (byte_cnt_q < BW'(4)) && (in_data != tiff_magic(byte_cnt_q[1:0]));
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    row_cnt_d  = row_cnt_q;
    pix_load   = 1'b0;
`ifdef TIFF_HDR_CHECK_EN
    err_set    = 1'b0;
    err_clr    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_HEADER;
          byte_cnt_d = '0;
          row_cnt_d  = '0;
`ifdef TIFF_HDR_CHECK_EN
          err_clr    = 1'b1;
`endif
        end
      end
      ST_HEADER: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == BW'(HDR_BYTES - 1)) begin
            state_d    = ST_PIXELS;
            byte_cnt_d = '0;
          end
`ifdef TIFF_HDR_CHECK_EN
          // Mismatch overrides the end-of-header move when the header is short.
          if (hdr_bad) begin
            state_d = ST_IDLE;
            err_set = 1'b1;
          end
`endif
        end
      end
      ST_PIXELS: begin
        if (accept) begin
          pix_load   = 1'b1;
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == BW'(COLUMNS - 1)) begin
            state_d    = ST_WRITE;
            byte_cnt_d = '0;
          end
        end
      end
      ST_WRITE: begin
        byte_cnt_d = '0;
        if (row_cnt_q == RW'(ROWS - 1)) begin
          state_d = ST_TRAILER;
        end else begin
          row_cnt_d = row_cnt_q + RW'(1);
          state_d   = ST_PIXELS;
        end
      end
      ST_TRAILER: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + BW'(1);
          if (byte_cnt_q == BW'(TRL_BYTES - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ST_HEADER) || (state_q == ST_PIXELS) || (state_q == ST_TRAILER);
    loading     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    frame_done  = (state_q == ST_DONE);
    write_array = '0;
    if (state_q == ST_WRITE) write_array = ROWS'(1) << row_cnt_q;
  end

`ifdef TIFF_HDR_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       error <= 1'b0;
    else if (err_clr) error <= 1'b0;
    else if (err_set) error <= 1'b1;
  end
`else
  assign error = 1'b0;
`endif

  tiff_row_assembler #(
    .COLUMNS (COLUMNS),
    .BW      (BW)
  ) u_assembler (
    .clk      (clk),
    .reset    (reset),
    .load_en  (pix_load),
    .lane     (byte_cnt_q),
    .byte_in  (in_data),
    .row_data (row_data)
  );

endmodule

// File: tb/tb_tiff_row_loader.sv
// Scoreboard bench for tiff_row_loader with a 4x4 array; rows are queued as driven
// and popped on each write strobe. Covers both builds of TIFF_HDR_CHECK_EN.
module tb_tiff_row_loader;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLUMNS = 4;
  localparam int unsigned HDR     = 8;
  localparam int unsigned TRL     = 126;
  localparam logic [63:0] GOOD_HDR = 64'h4D4D002A_00000008;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, loading, frame_done, error;
  logic [8*COLUMNS-1:0] row_data;
  logic [ROWS-1:0]      write_array;

  typedef struct packed {
    logic [ROWS-1:0]      wa;
    logic [8*COLUMNS-1:0] row;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned acc_idx  = 0;
  int unsigned done_cnt = 0;
  int unsigned done_exp = 0;
  bit          pend_strobe = 1'b0;
  bit          pend_done   = 1'b0;

  tiff_row_loader #(
    .ROWS      (ROWS),
    .COLUMNS   (COLUMNS),
    .HDR_BYTES (HDR),
    .TRL_BYTES (TRL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .row_data    (row_data),
    .write_array (write_array),
    .loading     (loading),
    .frame_done  (frame_done),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: predicts strobe and frame_done cycles from observed transfers.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      acc_idx     = 0;
      pend_strobe = 1'b0;
      pend_done   = 1'b0;
    end else begin
      if (pend_strobe || write_array != '0)
        check_eq("strobe_timing", 64'(write_array != '0), 64'(pend_strobe));
      if (write_array != '0) begin
        if (sb.size() == 0) begin
          check_eq("sb_pop", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check_eq("write_array", 64'(write_array), 64'(e.wa));
          check_eq("row_data", 64'(row_data), 64'(e.row));
        end
      end
      pend_strobe = 1'b0;
      if (pend_done || frame_done) begin
        check_eq("frame_done", 64'(frame_done), 64'(pend_done));
        if (frame_done) begin
          check_eq("loading_at_done", 64'(loading), 64'd0);
          done_cnt++;
        end
      end
      pend_done = 1'b0;
      if (start && !loading && !frame_done) acc_idx = 0;
      if (in_valid && in_ready) begin
        if (acc_idx >= HDR && acc_idx < HDR + ROWS*COLUMNS &&
            (acc_idx - HDR) % COLUMNS == COLUMNS - 1)
          pend_strobe = 1'b1;
        if (acc_idx == HDR + ROWS*COLUMNS + TRL - 1) pend_done = 1'b1;
        acc_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one byte and returns at edge+1 after it transfers.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned guard = 0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check_eq({tag, "_row_data"}, 64'(row_data), 64'd0);
    check_eq({tag, "_write_array"}, 64'(write_array), 64'd0);
    check_eq({tag, "_loading"}, 64'(loading), 64'd0);
    check_eq({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    check_eq({tag, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic send_frame(input logic [63:0] hdr, input bit gaps, input bit inj_start,
                            input int abort_row);
    logic [8*COLUMNS-1:0] rexp;
    exp_t e;
    pulse_start();
    check_eq("loading_rise", 64'(loading), 64'd1);
    check_eq("error_clr", 64'(error), 64'd0);
    for (int k = 0; k < int'(HDR); k++) send_byte(hdr[63-8*k -: 8], gaps);
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLUMNS); c++) rexp[8*c +: 8] = 8'(r*COLUMNS + c);
      for (int c = 0; c < int'(COLUMNS); c++) begin
        if (r == abort_row && c == 2) begin
          #2 reset = 1'b0;
          #1 check_reset_outputs("async_rst");
          #2 reset = 1'b1;
          tick();
          return;
        end
        if (c == int'(COLUMNS) - 1) begin
          e.wa  = ROWS'(1) << r;
          e.row = rexp;
          sb.push_back(e);
        end
        if (inj_start && r == 1 && c == 1) start = 1'b1;
        send_byte(8'(r*COLUMNS + c), gaps);
        start = 1'b0;
        if (inj_start && r == 1 && c == int'(COLUMNS) - 1) pulse_start();
      end
    end
    for (int t = 0; t < int'(TRL); t++) send_byte(8'(t) ^ 8'hA5, gaps);
    repeat (3) tick();
    done_exp++;
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    check_eq("frames_done", 64'(done_cnt), 64'(done_exp));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3 check_reset_outputs("reset");
    #10 reset = 1'b1;
    tick();

    send_frame(GOOD_HDR, 1'b0, 1'b0, -1);

`ifdef TIFF_HDR_CHECK_EN
    pulse_start();
    send_byte(8'h4D, 1'b0);
    send_byte(8'h4D, 1'b0);
    send_byte(8'h01, 1'b0);
    check_eq("hdr_error", 64'(error), 64'd1);
    check_eq("hdr_err_loading", 64'(loading), 64'd0);
    check_eq("hdr_err_in_ready", 64'(in_ready), 64'd0);
    repeat (3) tick();
    check_eq("hdr_err_sticky", 64'(error), 64'd1);
    send_frame(GOOD_HDR, 1'b0, 1'b0, -1);
`else
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, -1);
    check_eq("no_error_unchecked", 64'(error), 64'd0);
`endif

    send_frame(GOOD_HDR, 1'b1, 1'b0, -1);
    send_frame(GOOD_HDR, 1'b0, 1'b0, 2);
    send_frame(GOOD_HDR, 1'b0, 1'b0, -1);
    send_frame(GOOD_HDR, 1'b0, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tiff_row_loader.md
Name: tiff_row_loader

Overview:
- Inbound counterpart of the pixel readout path.
- Accepts the same big-endian TIFF byte stream that the readout side emits: 8-byte header, then ROWS×COLUMNS pixel bytes row by row, then the trailer bytes.
- Reassembles each row into the pixelDataOut packing and drives a one-hot row write strobe into the pixel array.
- Used to preload array contents at start-up and to replay captured images.

Parameters:
- ROWS, 256, number of rows; width of write_array.
- COLUMNS, 256, pixels per row; row_data is 8*COLUMNS bits.
- HDR_BYTES, 8, leading header bytes consumed before pixel data.
- TRL_BYTES, 126, trailer bytes consumed after the last row.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame load; honoured only in IDLE.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready.
- row_data  out  8*COLUMNS  assembled row; pixel i at bits [8i +: 8].
- write_array  out  ROWS  one-hot row write strobe, high for one cycle per row.
- loading  out  1  high from the cycle after start until frame completion or error.
- frame_done  out  1  one-cycle pulse when the trailer is fully consumed.
- error  out  1  sticky header-mismatch flag; cleared by the next accepted start.

Behaviour:
- Reset values: in_ready=0, row_data=0, write_array=0, loading=0, frame_done=0, error=0. State=IDLE, all counters 0.
- Reset is asynchronous and may arrive mid-frame: everything returns to reset values immediately, and the partial frame is discarded.
- States: IDLE, HEADER, PIXELS, WRITE, TRAILER, DONE.
- in_ready is 1 in HEADER, PIXELS and TRAILER, and 0 in IDLE, WRITE and DONE.
- IDLE:
  - start=1 → HEADER; error cleared; byte_cnt=0, row_cnt=0.
  - in_valid is ignored.
- HEADER:
  - Each accepted byte increments byte_cnt.
  - Byte k<4 is compared against 4D,4D,00,2A. On mismatch → IDLE with error=1 and loading=0.
  - After HDR_BYTES accepted → PIXELS, byte_cnt=0.
- PIXELS:
  - Accepted byte written to row_data[8*byte_cnt +: 8]; byte_cnt increments.
  - Acceptance of byte COLUMNS-1 → WRITE.
- WRITE (exactly one cycle, registered):
  - write_array = 1 << row_cnt.
  - row_data holds the complete row during this cycle.
  - Next state: row_cnt==ROWS-1 → TRAILER; otherwise row_cnt++ and → PIXELS with byte_cnt=0.
  - Latency: last pixel byte of a row accepted in cycle N, strobe in cycle N+1.
- row_data is not cleared between rows; each byte position is overwritten before the next strobe.
- TRAILER:
  - Consumes TRL_BYTES bytes without checking them.
  - After the last byte → DONE.
- DONE: frame_done=1 for one cycle, loading→0, → IDLE.
- A start pulse outside IDLE is ignored, with no effect on counters.
- in_valid gaps (backpressure from the source) simply stall the state; no timeout.
- Counter widths:
  - byte_cnt: $clog2(max(COLUMNS, HDR_BYTES, TRL_BYTES)) + 1 bits.
  - row_cnt: $clog2(ROWS) bits.
  - No wrap occurs because every transition is compared against an exact terminal count.

Optional Feature:
- Macro TIFF_HDR_CHECK_EN.
- Defined: magic comparison in HEADER is active, and the error path behaves as above.
- Undefined: header bytes are skipped unchecked, error is tied to 0, and no mismatch path is generated.

Decomposition:
- Shared package pixel_io_pkg holds:
  - The state enum typedef.
  - TIFF magic byte constants (4D,4D,00,2A).
  - Default HDR_BYTES/TRL_BYTES localparams, shared with the readout side so header and trailer lengths stay consistent.
- One sub-module, tiff_row_assembler: byte-lane write into the row register, indexed by byte_cnt, with a load enable. The FSM and counters stay in the top.

Test Plan (bench with ROWS=4, COLUMNS=4, HDR_BYTES=8, TRL_BYTES=126):
- Valid header, pixel bytes 00..0F, 126 trailer bytes, in_valid held high → write_array 0001,0010,0100,1000 in turn. row_data = 03020100, 07060504, 0B0A0908, 0F0E0D0C at the strobes. frame_done one cycle after the last trailer byte; loading falls in the same cycle.
- Header byte 2 = 0x01 (macro defined) → error=1, loading=0, no write_array pulse. Next start clears error and a good frame loads normally.
- Random in_valid gaps (~50% duty) on the same stream → identical row_data and strobe sequence; each strobe exactly one cycle after the fourth byte of its row.
- reset driven low while in PIXELS of row 2 → outputs to reset values asynchronously. A subsequent start and full frame load rows 0..3 correctly.
- start pulsed in PIXELS and in WRITE → no restart; counters and strobe sequence unchanged.
- Macro undefined, header bytes all 0xFF → frame loads as in the first scenario; error stays 0.
